// File: rtl/barret_2131_pkg.sv
// Shared constants and FSM encoding for the mod-2131 multiplier feeding the
// Barrett reducer.
package barret_2131_pkg;

   localparam int Q      = 2131;
   localparam int W_OP   = 12;
   localparam int W_PROD = 23;
   localparam int CNT_W  = $clog2(W_OP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/modmul_feed_2131.sv
// Sequential shift-add multiplier: forms a*b over exactly W_OP cycles and holds
// the product under valid/ready for the downstream barret_for_2131 reducer.
// Optional feature: define MODMUL_FEED_RANGE_CHECK_EN to flag out-of-range
// operands (product forced to 0, range_err raised while the result is held).
module modmul_feed_2131
   import barret_2131_pkg::state_t;
   import barret_2131_pkg::IDLE;
   import barret_2131_pkg::MUL;
   import barret_2131_pkg::HOLD;
#(
   parameter int Q      = barret_2131_pkg::Q,
   parameter int W_OP   = barret_2131_pkg::W_OP,
   parameter int W_PROD = barret_2131_pkg::W_PROD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_OP-1:0]   a,
   input  logic [W_OP-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W_PROD-1:0] product,
   output logic              range_err
);

   localparam int CW = $clog2(W_OP);

   // The modulus must fit the operand width, otherwise residues are not representable.
   if (Q > (1 << W_OP)) begin : g_bad_q
      $error("modmul_feed_2131: Q does not fit in W_OP bits");
   end
   if (W_PROD < 2 * W_OP - 1) begin : g_bad_prod
      $error("modmul_feed_2131: W_PROD too narrow for in-range products");
   end

   state_t            state, state_nxt;
   logic [W_PROD-1:0] a_sh;
   logic [W_OP-1:0]   b_sh;
   logic [W_PROD-1:0] acc;
   logic [CW-1:0]     cnt;
   logic              accept;
   logic              deliver;
   logic              last_iter;
   logic              err_q;

   assign accept    = in_valid && (state == IDLE);
   assign deliver   = out_ready && (state == HOLD);
   assign last_iter = (cnt == CW'(W_OP - 1));

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and handshake decodes (pure functions of registered state).
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = MUL;
         end
         MUL: begin
            if (last_iter) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift-add datapath: one multiplier bit per MUL cycle, no early exit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
         cnt  <= '0;
      end else if (accept) begin
         a_sh <= W_PROD'(a);
         b_sh <= b;
         acc  <= '0;
         cnt  <= '0;
      end else if (state == MUL) begin
         if (b_sh[0]) acc <= acc + a_sh;
         a_sh <= a_sh << 1;
         b_sh <= b_sh >> 1;
         cnt  <= cnt + 1'b1;
      end
   end

`ifdef MODMUL_FEED_RANGE_CHECK_EN
   // Remember an out-of-range operand from accept until the result is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       err_q <= 1'b0;
      else if (accept)  err_q <= (a >= W_OP'(Q)) || (b >= W_OP'(Q));
      else if (deliver) err_q <= 1'b0;
   end
`else
   // No range check: out-of-range operands are a caller error.
   assign err_q = 1'b0;
`endif

   // Product is only exposed in HOLD so partial sums never reach the reducer.
   always_comb begin
      product   = '0;
      range_err = 1'b0;
      if (state == HOLD) begin
         range_err = err_q;
         product   = err_q ? '0 : acc;
      end
   end

endmodule

// File: tb/tb_modmul_feed_2131.sv
// Directed self-checking bench for modmul_feed_2131 (honours
// MODMUL_FEED_RANGE_CHECK_EN if the build defines it).
module tb_modmul_feed_2131;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] a;
   logic [11:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] product;
   logic        range_err;

   int vecs = 0;
   int errs = 0;

   modmul_feed_2131 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one pair for a single cycle (caller ensures in_ready).
   task automatic send(input int av, input int bv);
      in_valid = 1'b1;
      a        = 12'(av);
      b        = 12'(bv);
      step();
      in_valid = 1'b0;
   endtask

   // Count edges after accept until out_valid; bounded.
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 20; i++) begin
         vecs++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 23'd0 || range_err !== 1'b0) begin
            errs++;
            $display("FAIL reset cyc%0d: in_ready=%b out_valid=%b product=%0d range_err=%b, want 1 0 0 0",
                     i, in_ready, out_valid, product, range_err);
         end
         step();
      end
   endtask

   task automatic test_basic();
      int n;
      out_ready = 1'b1;
      vecs++;
      if (in_ready !== 1'b1) begin
         errs++; $display("FAIL basic_ready: in_ready=%b want 1", in_ready);
      end
      send(1234, 2);
      wait_valid(n);
      vecs++;
      if (n !== 12) begin
         errs++; $display("FAIL basic_latency: got %0d cycles want 12", n);
      end
      vecs++;
      if (product !== 23'd2468) begin
         errs++; $display("FAIL basic_product: got %0d want 2468", product);
      end
      vecs++;
      if (in_ready !== 1'b0) begin
         errs++; $display("FAIL basic_excl: in_ready=%b want 0 while out_valid", in_ready);
      end
      step();
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++; $display("FAIL basic_after: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_corners();
      int n;
      out_ready = 1'b1;
      send(2130, 2130);
      wait_valid(n);
      vecs++;
      if (out_valid !== 1'b1 || product !== 23'd4536900) begin
         errs++; $display("FAIL max_product: valid=%b got %0d want 4536900", out_valid, product);
      end
      step();
      send(0, 2130);
      wait_valid(n);
      vecs++;
      if (out_valid !== 1'b1 || product !== 23'd0) begin
         errs++; $display("FAIL zero_a: valid=%b got %0d want 0", out_valid, product);
      end
      step();
      send(2130, 1);
      wait_valid(n);
      vecs++;
      if (out_valid !== 1'b1 || product !== 23'd2130) begin
         errs++; $display("FAIL one_b: valid=%b got %0d want 2130", out_valid, product);
      end
      step();
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      send(100, 50);
      wait_valid(n);
      // Offer a competing pair during HOLD; it must be ignored.
      in_valid = 1'b1;
      a = 12'd7;
      b = 12'd7;
      for (int i = 0; i < 30; i++) begin
         vecs++;
         if (out_valid !== 1'b1 || product !== 23'd5000 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL stall cyc%0d: valid=%b product=%0d in_ready=%b want 1 5000 0",
                     i, out_valid, product, in_ready);
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++; $display("FAIL stall_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      out_ready = 1'b1;
      send(55, 66);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 23'd0) begin
         errs++; $display("FAIL mid_reset: out_valid=%b in_ready=%b product=%0d want 0 1 0",
                          out_valid, in_ready, product);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      vecs++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errs++; $display("FAIL post_reset: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      send(7, 9);
      wait_valid(n);
      vecs++;
      if (n !== 12 || product !== 23'd63) begin
         errs++; $display("FAIL post_reset_mul: lat=%0d product=%0d want 12 63", n, product);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      int vld_at;
      int rdy_at;
      logic [22:0] p1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = 12'd3;
      b = 12'd4;
      step();
      a = 12'd5;
      b = 12'd6;
      n = 0;
      vld_at = -1;
      rdy_at = -1;
      p1 = '0;
      while (rdy_at < 0 && n < 40) begin
         step();
         n++;
         if (out_valid && vld_at < 0) begin
            vld_at = n;
            p1 = product;
         end
         if (in_ready) rdy_at = n;
      end
      vecs++;
      if (vld_at !== 12 || p1 !== 23'd12) begin
         errs++; $display("FAIL b2b_first: valid_at=%0d product=%0d want 12 12", vld_at, p1);
      end
      vecs++;
      if (rdy_at !== 13) begin
         errs++; $display("FAIL b2b_ready: ready_at=%0d want 13", rdy_at);
      end
      step();
      in_valid = 1'b0;
      wait_valid(n);
      vecs++;
      if (n !== 12 || product !== 23'd30) begin
         errs++; $display("FAIL b2b_second: lat=%0d product=%0d want 12 30", n, product);
      end
      step();
   endtask

   task automatic test_range();
      int n;
      logic [22:0] exp_p;
      logic        exp_e;
`ifdef MODMUL_FEED_RANGE_CHECK_EN
      exp_p = 23'd0;
      exp_e = 1'b1;
`else
      exp_p = 23'd10655;
      exp_e = 1'b0;
`endif
      out_ready = 1'b0;
      send(2131, 5);
      wait_valid(n);
      vecs++;
      if (n !== 12 || product !== exp_p || range_err !== exp_e) begin
         errs++; $display("FAIL range: lat=%0d product=%0d range_err=%b want 12 %0d %b",
                          n, product, range_err, exp_p, exp_e);
      end
      step();
      vecs++;
      if (product !== exp_p || range_err !== exp_e) begin
         errs++; $display("FAIL range_hold: product=%0d range_err=%b want %0d %b",
                          product, range_err, exp_p, exp_e);
      end
      out_ready = 1'b1;
      step();
      vecs++;
      if (range_err !== 1'b0 || in_ready !== 1'b1) begin
         errs++; $display("FAIL range_clear: range_err=%b in_ready=%b want 0 1", range_err, in_ready);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #23 rst_n = 1'b1;
      step();
      test_reset();
      test_basic();
      test_corners();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_range();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
